// File: rtl/iq_sample_fifo_pkg.sv
// Shared definitions for the I/Q sample FIFO: default geometry and the sample layout.
package iq_sample_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;

   // One complex sample: in-phase half in the upper 16 bits, quadrature in the lower.
   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
   } iq_sample_t;

endpackage

// File: rtl/iq_sample_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// Written without reset on the storage or the read register so it maps onto SB_RAM40_4K.
module iq_sample_fifo_ram
   import iq_sample_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_sys_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Write port: store the word when enabled.
   always_ff @(posedge i_sys_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: registered, holds its value whenever no read is enabled.
   always_ff @(posedge i_sys_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_sample_fifo.sv
// Single-clock FIFO for 32-bit complex I/Q samples between the LVDS deserialiser and the
// SMI readout. Pointers carry one extra wrap bit; flags and count are registered from the
// next-state pointers so they never lag the data path.
module iq_sample_fifo
   import iq_sample_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_sys_clk,
   input  logic                  i_reset,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  overflow_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ZERO  = '0;

   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;
   logic                  r_rd_zero;

   logic                  w_push;
   logic                  w_pull;
   logic                  w_drop;
   logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_rd_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [DATA_WIDTH-1:0] w_ram_rdata;

   // Accept decisions use the registered flags; reset blocks both so the RAM is left untouched.
   assign w_push = wr_en_i && !r_full  && !i_reset;
   assign w_pull = rd_en_i && !r_empty && !i_reset;
   assign w_drop = wr_en_i && r_full;

   assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_push};
   assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_pull};
   assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

   iq_sample_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_sys_clk (i_sys_clk),
      .i_we      (w_push),
      .i_waddr   (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wdata   (wr_data_i),
      .i_re      (w_pull),
      .i_raddr   (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rdata   (w_ram_rdata)
   );

   // Pointer, count and flag state; flags come from the next-state pointers.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == DEPTH);
         r_empty  <= (w_count_nxt == ZERO);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // The RAM read register cannot be reset, so output zero until the first accepted pull.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_rd_zero <= 1'b1;
      end else if (w_pull) begin
         r_rd_zero <= 1'b0;
      end
   end

   assign rd_data_o  = r_rd_zero ? '0 : w_ram_rdata;
   assign full_o     = r_full;
   assign empty_o    = r_empty;
   assign count_o    = r_count;
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo: inputs change and outputs are sampled on the falling edge.
module tb_iq_sample_fifo;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        full;
   logic        empty;
   logic [8:0]  count;
   logic        ovf;

   int n_checks;
   int n_fail;

   iq_sample_fifo dut (
      .i_sys_clk  (clk),
      .i_reset    (rst),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .rd_en_i    (rd_en),
      .rd_data_o  (rd_data),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pull_chk(input string tag, input logic [31:0] exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check(tag, rd_data, exp);
   endtask

   task automatic both(input logic [31:0] d);
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_data  = '0;
      @(negedge clk);

      // 1. Reset state
      do_reset();
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full",  {31'd0, full},  32'd0);
      check("rst_count", {23'd0, count}, 32'd0);
      check("rst_rdata", rd_data,        32'd0);
      check("rst_ovf",   {31'd0, ovf},   32'd0);

      // 2. Ordering
      push(32'h0001_0002);
      check("ord_empty_fall", {31'd0, empty}, 32'd0);
      push(32'h0003_0004);
      push(32'h0005_0006);
      check("ord_count3", {23'd0, count}, 32'd3);
      pull_chk("ord_d0", 32'h0001_0002);
      check("ord_count2", {23'd0, count}, 32'd2);
      pull_chk("ord_d1", 32'h0003_0004);
      check("ord_count1", {23'd0, count}, 32'd1);
      pull_chk("ord_d2", 32'h0005_0006);
      check("ord_count0", {23'd0, count}, 32'd0);
      check("ord_empty",  {31'd0, empty}, 32'd1);

      // 3. Full and overflow
      for (int i = 0; i < 256; i++) push(32'(i));
      check("full_flag",  {31'd0, full},  32'd1);
      check("full_count", {23'd0, count}, 32'd256);
      check("full_ovf0",  {31'd0, ovf},   32'd0);
      push(32'hDEAD_BEEF);
      check("full_ovf1",  {31'd0, ovf},   32'd1);
      check("full_count_hold", {23'd0, count}, 32'd256);
      for (int i = 0; i < 256; i++) pull_chk("full_drain", 32'(i));
      check("full_drained_empty", {31'd0, empty}, 32'd1);
      check("full_ovf_sticky",    {31'd0, ovf},   32'd1);

      // 4. Pointer wrap
      do_reset();
      for (int i = 0; i < 200; i++) push(32'(500 + i));
      for (int i = 0; i < 200; i++) pull_chk("wrap_pre", 32'(500 + i));
      for (int i = 0; i < 100; i++) push(32'(1000 + i));
      check("wrap_count", {23'd0, count}, 32'd100);
      for (int i = 0; i < 100; i++) pull_chk("wrap_data", 32'(1000 + i));
      check("wrap_empty", {31'd0, empty}, 32'd1);

      // 5a. Simultaneous push/pull mid-range
      for (int i = 0; i < 5; i++) push(32'(10 + i));
      both(32'd15);
      check("sim5_count", {23'd0, count}, 32'd5);
      check("sim5_rdata", rd_data, 32'd10);
      for (int i = 0; i < 5; i++) pull_chk("sim5_drain", 32'(11 + i));

      // 5b. Simultaneous push/pull when full
      for (int i = 0; i < 256; i++) push(32'(2000 + i));
      check("simf_full", {31'd0, full}, 32'd1);
      both(32'hDEAD_BEEF);
      check("simf_count", {23'd0, count}, 32'd255);
      check("simf_ovf",   {31'd0, ovf},   32'd1);
      check("simf_rdata", rd_data,        32'd2000);
      check("simf_full0", {31'd0, full},  32'd0);
      for (int i = 1; i < 256; i++) pull_chk("simf_drain", 32'(2000 + i));
      check("simf_empty", {31'd0, empty}, 32'd1);

      // 5c. Simultaneous push/pull when empty
      both(32'h1234_5678);
      check("sime_count", {23'd0, count}, 32'd1);
      check("sime_rdata", rd_data, 32'(2255));
      check("sime_empty", {31'd0, empty}, 32'd0);
      pull_chk("sime_pull", 32'h1234_5678);

      // 6. Pull on empty, then reset with data stored
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pe_rdata", rd_data, 32'h1234_5678);
      check("pe_count", {23'd0, count}, 32'd0);
      check("pe_empty", {31'd0, empty}, 32'd1);
      for (int i = 0; i < 10; i++) push(32'(3000 + i));
      check("mr_count10", {23'd0, count}, 32'd10);
      check("mr_ovf_pre", {31'd0, ovf},   32'd1);
      rst   = 1'b1;
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 32'hCAFE_F00D;
      tick();
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("mr_empty", {31'd0, empty}, 32'd1);
      check("mr_count", {23'd0, count}, 32'd0);
      check("mr_ovf",   {31'd0, ovf},   32'd0);
      check("mr_full",  {31'd0, full},  32'd0);
      check("mr_rdata", rd_data,        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
